// File: rtl/calc_pkg.sv
// Constants shared by control_unit, bin_to_bcd_seq and DisplayRotator:
// converter FSM encodings, display width and operand width.
package calc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DISP_DIGITS = 8;
  localparam int OPERAND_W   = 32;

  // Decimal digits needed to hold any w-bit unsigned value.
  function automatic int calc_int_digits(input int w);
    return (w * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble add-3 cell: a digit of 5 or more is pre-biased so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with leading-zero blank
// mask and overflow flag for the display.
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH  = OPERAND_W,
  parameter int DIGITS = DISP_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int INT_DIGITS = calc_int_digits(WIDTH);
  localparam int BCD_W      = INT_DIGITS * 4;
  localparam int CNT_W      = $clog2(WIDTH);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;
  logic [DIGITS-1:0]   blank_q, blank_d, blank_calc;
  logic                ovf_q, ovf_d, ovf_calc;
  logic                done_q, done_d;
  logic                upper_zero;

  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (bcd_adj[4*g +: 4])
    );
  end

  // Overflow is any nonzero digit beyond the display; blanking walks down
  // from the top digit and stops at the first nonzero one.
  always_comb begin
    ovf_calc = 1'b0;
    for (int i = DIGITS; i < INT_DIGITS; i++) begin
      ovf_calc = ovf_calc | (|bcd_q[4*i +: 4]);
    end
    blank_calc = '0;
    upper_zero = !ovf_calc;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (bcd_q[4*i +: 4] == 4'd0);
      blank_calc[i] = upper_zero;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    bcd_out_d = bcd_out_q;
    blank_d   = blank_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = BCD_W'({bcd_adj, bin_q[WIDTH-1]});
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_out_d = bcd_q[4*DIGITS-1:0];
        blank_d   = blank_calc;
        ovf_d     = ovf_calc;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      bcd_out_q <= '0;
      blank_q   <= BLANK_RST;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      bcd_out_q <= bcd_out_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = done_q;
  assign bcd_out  = bcd_out_q;
  assign blank    = blank_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with an arithmetic reference model
// checked every cycle plus literal expectations per scenario.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bin_in;
  logic        start;
  logic        busy, done, overflow;
  logic [31:0] bcd_out;
  logic [7:0]  blank;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .bin_in   (bin_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .blank    (blank),
    .overflow (overflow)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected display fields for value v, from decimal arithmetic.
  function automatic void conv(input longint unsigned v, output logic [31:0] b,
                               output logic [7:0] bl, output logic o);
    longint unsigned p;
    b = '0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    o = (v > 64'd99999999);
    bl = '0;
    p = 10;
    for (int i = 1; i < 8; i++) begin
      bl[i] = !o && (v < p);
      p = p * 10;
    end
  endfunction

  // Reference model: transaction-level view of acceptance and timing.
  int          edge_n = 0;
  int          acc    = -1;
  logic [31:0] pend;
  logic        m_valid = 1'b0;
  logic        m_busy, m_done, m_ovf;
  logic [31:0] m_bcd;
  logic [7:0]  m_blank;

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      m_valid = 1'b1;
      acc     = -1;
      m_bcd   = '0;
      m_blank = 8'hFE;
      m_ovf   = 1'b0;
      m_done  = 1'b0;
      m_busy  = 1'b0;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (acc >= 0 && edge_n == acc + 33) begin
        conv({32'd0, pend}, m_bcd, m_blank, m_ovf);
        m_done = 1'b1;
      end
      if (start && (acc < 0 || edge_n >= acc + 34)) begin
        acc  = edge_n;
        pend = bin_in;
      end
      m_busy = (acc >= 0) && (edge_n >= acc) && (edge_n <= acc + 31);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("bcd_out", 64'(bcd_out), 64'(m_bcd));
      chk("blank", 64'(blank), 64'(m_blank));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run(input logic [31:0] v, input logic [31:0] eb, input logic [7:0] ebl,
                     input logic eo, input string nm);
    int lat, bcnt;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk({nm, "_latency"}, 64'(lat), 64'd33);
    chk({nm, "_busycycles"}, 64'(bcnt), 64'd32);
    chk({nm, "_bcd"}, 64'(bcd_out), 64'(eb));
    chk({nm, "_blank"}, 64'(blank), 64'(ebl));
    chk({nm, "_ovf"}, 64'(overflow), 64'(eo));
  endtask

  task automatic count_dones(input int cycles, input string nm);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk(nm, 64'(n), 64'd0);
  endtask

  initial begin
    int lat, bcnt;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("rst_blank", 64'(blank), 64'hFE);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;

    run(32'd0,          32'h0000_0000, 8'hFE, 1'b0, "zero");
    run(32'd12345678,   32'h1234_5678, 8'h00, 1'b0, "d12345678");
    run(32'd99999999,   32'h9999_9999, 8'h00, 1'b0, "max8");
    run(32'd100000000,  32'h0000_0000, 8'h00, 1'b1, "ovf_min");
    run(32'hFFFF_FFFF,  32'h9496_7295, 8'h00, 1'b1, "all_ones");

    // Second start and operand change mid-conversion are ignored.
    @(negedge clk);
    bin_in = 32'd42;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    bin_in = 32'd7;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_start_done_seen", 64'(done), 64'd1);
    chk("busy_start_bcd", 64'(bcd_out), 64'h42);
    chk("busy_start_blank", 64'(blank), 64'hFC);
    count_dones(40, "busy_start_extra_done");

    // Reset in the middle of a conversion.
    @(negedge clk);
    bin_in = 32'd12345678;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_bcd", 64'(bcd_out), 64'd0);
    chk("midrst_blank", 64'(blank), 64'hFE);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    count_dones(40, "midrst_no_done");
    run(32'd12345678, 32'h1234_5678, 8'h00, 1'b0, "after_rst");

    // Back-to-back: restart in the done cycle.
    @(negedge clk);
    bin_in = 32'd99999999;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b_first_bcd", 64'(bcd_out), 64'h9999_9999);
    bin_in = 32'd305;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b_latency", 64'(lat), 64'd33);
    chk("b2b_bcd", 64'(bcd_out), 64'h305);
    chk("b2b_blank", 64'(blank), 64'hF8);
    chk("b2b_ovf", 64'(overflow), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
